// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg
//   Shared constants for the 3x3 window generator and its consumer (conv_layer).
//   - DEFAULT_BIT_DEPTH : default pixel word width
//   - WIN_TAPS          : number of words in one packed window
//   - tap_lsb()         : LSB position of tap k (0=top-left .. 8=bottom-right)
//                         inside the packed window; tap k occupies
//                         [bd*(9-k)-1 : bd*(8-k)]. conv_layer unpacks the
//                         same way, so both sides must use this function.
package conv_window_gen_pkg;

  localparam int DEFAULT_BIT_DEPTH = 16;
  localparam int WIN_TAPS          = 9;

  function automatic int tap_lsb(input int bd, input int k);
    return bd * (WIN_TAPS - 1 - k);
  endfunction

endpackage

// File: rtl/conv_window_gen_line_delay.sv
// line_delay
//   One image line of pixel storage, addressed by column. The read port is
//   asynchronous, so dout shows the word written one line earlier at the same
//   column; the write at the clock edge lands after that read
//   (read-before-write).
// Ports:
//   clk  : clock
//   en   : write enable (one accepted pixel)
//   addr : column index
//   din  : word to store at addr
//   dout : word currently stored at addr
module line_delay #(
  parameter int bit_depth = 16,
  parameter int DEPTH     = 28,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [AW-1:0]        addr,
  input  logic [bit_depth-1:0] din,
  output logic [bit_depth-1:0] dout
);

  // Deliberately not reset: contents are overwritten before they can reach a
  // window (rows 0-1 never produce output).
  logic [bit_depth-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Turns a raster pixel stream into packed 3x3 windows for conv_layer.
//   Two line stores supply the two rows above the incoming pixel; a 3x3
//   register window shifts left on every accepted pixel. A window is emitted
//   (registered, one cycle after the accepting edge) whenever the accepted
//   pixel sits at row>=2 and col>=2, so no window ever spans a line wrap.
// Ports:
//   clk        : clock, all logic on posedge
//   RESET      : synchronous active-high reset
//   start      : frame-active level; low clears frame position and done flag
//   de         : pixel valid
//   pix        : pixel data, sampled when de=1
//   win        : packed window, top-left in the MSBs, bottom-right in the LSBs
//   win_de     : one-cycle strobe marking a new window on win
//   frame_done : one-cycle pulse together with the last window of the frame
// Handshake: a pixel is taken on every posedge where de && start && !done.
//   There is no back-pressure; win/win_de is a pure valid strobe and win holds
//   its last value while win_de is low.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int bit_depth = DEFAULT_BIT_DEPTH,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          start,
  input  logic                          de,
  input  logic [bit_depth-1:0]          pix,
  output logic [bit_depth*WIN_TAPS-1:0] win,
  output logic                          win_de,
  output logic                          frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic                 done;
  logic                 accept;
  logic                 last_col;
  logic                 last_row;
  logic                 win_pos;
  logic [bit_depth-1:0] tap_a;  // one line above the incoming pixel
  logic [bit_depth-1:0] tap_b;  // two lines above the incoming pixel

  logic [bit_depth-1:0]          w     [WIN_TAPS];
  logic [bit_depth-1:0]          w_nxt [WIN_TAPS];
  logic [bit_depth*WIN_TAPS-1:0] win_nxt;

  assign accept   = de && start && !done;
  assign last_col = (col == COL_W'(IMG_W - 1));
  assign last_row = (row == ROW_W'(IMG_H - 1));
  assign win_pos  = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // lineA delays the pixel by one line; lineB delays lineA's output by one
  // more line, so at a given column they present rows r-1 and r-2.
  line_delay #(.bit_depth(bit_depth), .DEPTH(IMG_W)) u_line_a (
    .clk  (clk),
    .en   (accept),
    .addr (col),
    .din  (pix),
    .dout (tap_a)
  );

  line_delay #(.bit_depth(bit_depth), .DEPTH(IMG_W)) u_line_b (
    .clk  (clk),
    .en   (accept),
    .addr (col),
    .din  (tap_a),
    .dout (tap_b)
  );

  // Next window: each row shifts left, new right column is {lineB, lineA, pix}.
  always_comb begin
    w_nxt[0] = w[1];
    w_nxt[1] = w[2];
    w_nxt[2] = tap_b;
    w_nxt[3] = w[4];
    w_nxt[4] = w[5];
    w_nxt[5] = tap_a;
    w_nxt[6] = w[7];
    w_nxt[7] = w[8];
    w_nxt[8] = pix;
    win_nxt  = '0;
    for (int k = 0; k < WIN_TAPS; k++) begin
      win_nxt[tap_lsb(bit_depth, k) +: bit_depth] = w_nxt[k];
    end
  end

  // Window registers carry no reset; stale columns are masked by win_pos.
  always_ff @(posedge clk) begin
    if (!RESET && accept) w <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      col        <= '0;
      row        <= '0;
      done       <= 1'b0;
      win        <= '0;
      win_de     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_de     <= 1'b0;
      frame_done <= 1'b0;
      if (!start) begin
        col  <= '0;
        row  <= '0;
        done <= 1'b0;
      end else if (accept) begin
        if (win_pos) begin
          win        <= win_nxt;
          win_de     <= 1'b1;
          frame_done <= last_col && last_row;
        end
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row  <= '0;
            done <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen
//   Directed bench for conv_window_gen. A 5x5 instance covers the streaming,
//   stall, after-done, reset and start-drop scenarios with pix=row*5+col+off;
//   a default 28x28 instance takes a random frame with ~70% de duty and is
//   compared against a 3x3 extraction from the stored image.
module tb_conv_window_gen;

  localparam int BD = 16;
  localparam int WW = BD * 9;
  localparam int LW = 28;
  localparam int LH = 28;

  logic clk = 1'b0;
  logic RESET = 1'b1;

  logic          s_start = 1'b0, s_de = 1'b0;
  logic [BD-1:0] s_pix = '0;
  logic [WW-1:0] s_win;
  logic          s_win_de, s_fd;

  logic          l_start = 1'b0, l_de = 1'b0;
  logic [BD-1:0] l_pix = '0;
  logic [WW-1:0] l_win;
  logic          l_win_de, l_fd;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  conv_window_gen #(.bit_depth(BD), .IMG_W(5), .IMG_H(5)) dut_s (
    .clk(clk), .RESET(RESET), .start(s_start), .de(s_de), .pix(s_pix),
    .win(s_win), .win_de(s_win_de), .frame_done(s_fd)
  );

  conv_window_gen #(.bit_depth(BD), .IMG_W(LW), .IMG_H(LH)) dut_l (
    .clk(clk), .RESET(RESET), .start(l_start), .de(l_de), .pix(l_pix),
    .win(l_win), .win_de(l_win_de), .frame_done(l_fd)
  );

  // ---------------- scoreboard / capture ----------------
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] got_q[$];
  logic          got_fd_q[$];
  logic [WW-1:0] l_got_q[$];
  logic          l_got_fd_q[$];
  int fd_cnt = 0, fd_stray = 0, stall_viol = 0, l_fd_cnt = 0;
  logic s_de_q = 1'b0;
  logic [BD-1:0] img [LH][LW];

  always @(posedge clk) s_de_q <= s_de;

  always @(negedge clk) begin
    if (s_win_de) begin
      got_q.push_back(s_win);
      got_fd_q.push_back(s_fd);
      if (!s_de_q) stall_viol++;
    end
    if (s_fd) fd_cnt++;
    if (s_fd && !s_win_de) fd_stray++;
  end

  always @(negedge clk) begin
    if (l_win_de) begin
      l_got_q.push_back(l_win);
      l_got_fd_q.push_back(l_fd);
    end
    if (l_fd) l_fd_cnt++;
  end

  // ---------------- models ----------------
  function automatic logic [WW-1:0] small_win(input int off, input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[BD*(8-(dr*3+dc)) +: BD] = BD'((r-2+dr)*5 + (c-2+dc) + off);
    return w;
  endfunction

  function automatic logic [WW-1:0] large_win(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[BD*(8-(dr*3+dc)) +: BD] = img[r-2+dr][c-2+dc];
    return w;
  endfunction

  task automatic build_small_exp(input int off);
    exp_q.delete();
    for (int r = 2; r < 5; r++)
      for (int c = 2; c < 5; c++)
        exp_q.push_back(small_win(off, r, c));
  endtask

  task automatic clear_small;
    got_q.delete();
    got_fd_q.delete();
    fd_cnt = 0;
    fd_stray = 0;
    stall_viol = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic restart_small;
    @(negedge clk);
    s_start = 1'b0;
    s_de    = 1'b0;
    @(negedge clk);
    s_start = 1'b1;
  endtask

  task automatic send_small(input int v);
    @(negedge clk);
    s_de  = 1'b1;
    s_pix = BD'(v);
  endtask

  task automatic drive_small_frame(input int off, input bit stall);
    for (int i = 0; i < 25; i++) begin
      send_small(i + off);
      if (stall && (i % 2 == 1)) begin
        repeat (3) begin
          @(negedge clk);
          s_de = 1'b0;
        end
      end
    end
    @(negedge clk);
    s_de = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    RESET = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (s_win !== '0 || s_win_de !== 1'b0 || s_fd !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_small: win=%h win_de=%b fd=%b, want 0/0/0", s_win, s_win_de, s_fd);
    end
    n_checks++;
    if (l_win !== '0 || l_win_de !== 1'b0 || l_fd !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_large: win=%h win_de=%b fd=%b, want 0/0/0", l_win, l_win_de, l_fd);
    end
    RESET = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream(input bit stall, input string tag);
    clear_small();
    restart_small();
    drive_small_frame(0, stall);
    build_small_exp(0);
    n_checks++;
    if (got_q.size() != 9) begin
      n_errors++;
      $display("FAIL %s_count: got %0d windows, want 9", tag, got_q.size());
    end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL %s_win%0d: got %h want %h", tag, i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (fd_cnt != 1 || fd_stray != 0 || got_fd_q.size() != 9 || got_fd_q[got_fd_q.size()-1] !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_frame_done: pulses=%0d stray=%0d, want 1 pulse on last window", tag, fd_cnt, fd_stray);
    end
    n_checks++;
    if (stall_viol != 0) begin
      n_errors++;
      $display("FAIL %s_stall_strobe: %0d strobes without accept, want 0", tag, stall_viol);
    end
    n_checks++;
    if (s_win !== small_win(0, 4, 4)) begin
      n_errors++;
      $display("FAIL %s_win_hold: win=%h want %h", tag, s_win, small_win(0, 4, 4));
    end
  endtask

  task automatic test_after_done;
    clear_small();
    restart_small();
    drive_small_frame(0, 1'b0);
    clear_small();
    for (int i = 0; i < 10; i++) send_small(500 + i);
    @(negedge clk);
    s_de = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (got_q.size() != 0) begin
      n_errors++;
      $display("FAIL after_done_ignored: got %0d windows, want 0", got_q.size());
    end
    clear_small();
    restart_small();
    drive_small_frame(100, 1'b0);
    n_checks++;
    if (got_q.size() != 9) begin
      n_errors++;
      $display("FAIL second_frame_count: got %0d, want 9", got_q.size());
    end
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== small_win(100, 2, 2)) begin
      n_errors++;
      $display("FAIL second_frame_first: got %h want %h",
               (got_q.size() > 0) ? got_q[0] : '0, small_win(100, 2, 2));
    end
  endtask

  task automatic test_reset_mid;
    clear_small();
    restart_small();
    for (int i = 0; i <= 15; i++) send_small(i);
    // Reset coincides with a valid pixel; the pixel must be dropped.
    @(negedge clk);
    RESET = 1'b1;
    s_de  = 1'b1;
    s_pix = BD'(999);
    @(negedge clk);
    n_checks++;
    if (s_win !== '0 || s_win_de !== 1'b0 || s_fd !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: win=%h win_de=%b fd=%b, want 0/0/0", s_win, s_win_de, s_fd);
    end
    RESET = 1'b0;
    s_de  = 1'b0;
    clear_small();
    drive_small_frame(200, 1'b0);
    build_small_exp(200);
    n_checks++;
    if (got_q.size() != 9) begin
      n_errors++;
      $display("FAIL reset_mid_count: got %0d, want 9", got_q.size());
    end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL reset_mid_win%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_drop;
    clear_small();
    restart_small();
    for (int i = 0; i <= 13; i++) send_small(i);
    @(negedge clk);
    s_start = 1'b0;
    s_de    = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (got_q.size() != 2) begin
      n_errors++;
      $display("FAIL start_drop_count: got %0d, want 2", got_q.size());
    end
    n_checks++;
    if (got_q.size() < 2 || got_q[1] !== small_win(0, 2, 3)) begin
      n_errors++;
      $display("FAIL start_drop_pending: got %h want %h",
               (got_q.size() > 1) ? got_q[1] : '0, small_win(0, 2, 3));
    end
    clear_small();
    restart_small();
    drive_small_frame(50, 1'b0);
    build_small_exp(50);
    n_checks++;
    if (got_q.size() != 9) begin
      n_errors++;
      $display("FAIL start_drop_next_count: got %0d, want 9", got_q.size());
    end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL start_drop_next_win%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_large;
    int bad;
    bad = 0;
    for (int r = 0; r < LH; r++)
      for (int c = 0; c < LW; c++)
        img[r][c] = BD'($urandom_range(0, 65535));
    exp_q.delete();
    for (int r = 2; r < LH; r++)
      for (int c = 2; c < LW; c++)
        exp_q.push_back(large_win(r, c));
    l_got_q.delete();
    l_got_fd_q.delete();
    l_fd_cnt = 0;
    @(negedge clk);
    l_start = 1'b1;
    for (int r = 0; r < LH; r++) begin
      for (int c = 0; c < LW; c++) begin
        while ($urandom_range(0, 9) >= 7) begin
          @(negedge clk);
          l_de = 1'b0;
        end
        @(negedge clk);
        l_de  = 1'b1;
        l_pix = img[r][c];
      end
    end
    @(negedge clk);
    l_de = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (l_got_q.size() != 676) begin
      n_errors++;
      $display("FAIL large_count: got %0d windows, want 676", l_got_q.size());
    end
    for (int i = 0; i < 676 && i < l_got_q.size(); i++) begin
      n_checks++;
      if (l_got_q[i] !== exp_q[i]) begin
        n_errors++;
        bad++;
        if (bad <= 5) $display("FAIL large_win%0d: got %h want %h", i, l_got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (l_fd_cnt != 1 || l_got_fd_q.size() == 0 || l_got_fd_q[l_got_fd_q.size()-1] !== 1'b1) begin
      n_errors++;
      $display("FAIL large_frame_done: pulses=%0d, want 1 on last window", l_fd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream(1'b0, "continuous");
    test_stream(1'b1, "stalled");
    test_after_done();
    test_reset_mid();
    test_start_drop();
    test_random_large();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net: the run is a few thousand cycles; stop if it ever runs away.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the convolution layer: turns a raster pixel stream (one pixel per de cycle) into packed 3x3 windows for the layer's 9-word `in` bus.
- Holds two full image lines in internal line stores plus a 3x3 register window.
- Emits one window per accepted pixel once two full rows and two columns of history exist.
- Sits between the frame source/sampler and conv_layer; its window/valid outputs drive that layer's in/de directly.

Parameters:
bit_depth, 16, pixel word width; must match the conv layer
IMG_W, 28, pixels per line (>=3)
IMG_H, 28, lines per frame (>=3)

Ports:
clk  input  1  single clock, all logic on posedge
RESET  input  1  synchronous, active-high reset
start  input  1  frame-active level; low clears frame position (counters only)
de  input  1  pixel valid; one pixel accepted per cycle with de=1
pix  input  bit_depth  pixel data, sampled when de=1
win  output  bit_depth*9  window, row-major: top-left in [bit_depth*9-1:bit_depth*8] ... bottom-right in [bit_depth-1:0]
win_de  output  1  win valid, one-cycle strobe per window
frame_done  output  1  one-cycle pulse coinciding with the final window of the frame

Behaviour:
- Reset (RESET=1 at posedge):
  - win=0, win_de=0, frame_done=0.
  - col=0, row=0, done flag cleared.
  - Line store contents are not cleared and are don't-care.
- Accept: de=1 && start=1 && !done.
  - Stall: de=0 mid-line pauses with no state change. A line ends only by pixel count (col==IMG_W-1), never on a de falling edge.
- Position counters: col in [0,IMG_W-1], row in [0,IMG_H-1], width $clog2 of each bound.
  - Each accept: col++.
  - At col==IMG_W-1: col wraps to 0 and row++.
  - At row==IMG_H-1 && col==IMG_W-1: set done; row and col return to 0.
- Line stores: two depth-IMG_W delay lines. On each accept:
  - lineB[col] <= lineA[col];
  - lineA[col] <= pix;
  - tap values are read before the write (read-before-write).
- Window registers: 3 rows x 3 words. On accept, each row shifts left by one word and new right column = {lineB[col], lineA[col], pix} (top, mid, bottom).
- Output, registered, latency 1 cycle after the accepting posedge:
  - win_de=1 iff the accepted pixel had row>=2 && col>=2.
  - win holds the window with bottom-right = that pixel.
  - win holds its value when win_de=0.
- Window count per frame: (IMG_H-2)*(IMG_W-2); 676 at defaults.
- No windows spanning a line boundary: windows at col 0 and col 1 are suppressed even though the registers hold stale columns.
- frame_done: asserts in the same cycle as win_de for pixel (IMG_H-1, IMG_W-1).
- After done:
  - de is ignored until start goes low.
  - start low, then high, begins a new frame at (0,0).
  - The line stores are reused without clearing; rows 0–1 produce no windows, so stale data never escapes.
- start=0 while mid-frame:
  - row=0, col=0, done=0 next cycle; no win_de.
  - An in-flight output strobe from the previous cycle still completes.
- RESET mid-frame: same as power-up reset; the partial frame is discarded.
- Simultaneous RESET and de=1: RESET wins; the pixel is dropped.
- Arithmetic: pure data movement, no arithmetic on pixel values; pixels pass bit-exact.

Decomposition:
- Shared package:
  - bit_depth default.
  - WIN_TAPS=9.
  - Packing-order constant/function mapping tap index k (0=top-left … 8=bottom-right) to slice [bit_depth*(9-k)-1 : bit_depth*(8-k)]. conv_layer unpacks with the same mapping.
- Sub-module `line_delay`:
  - Parameters bit_depth and DEPTH; inputs en, addr, din; output dout (read-before-write).
  - Instantiated twice (lineA, lineB), register- or BRAM-mappable.

Test Plan:
- IMG_W=5, IMG_H=5, pix=row*5+col streamed continuously:
  - exactly 9 win_de strobes.
  - first window (cycle after pixel 12) = {0,1,2,5,6,7,10,11,12}.
  - last = {12,13,14,17,18,19,22,23,24}, with frame_done=1 in that cycle only.
- Same frame with de deasserted for 3 cycles after every second pixel: identical window sequence and count; win_de never asserted during stalls.
- Frame done, then de held high with start=1 for 10 more cycles: no win_de. Then start 0 for 1 cycle, then 1, and a second frame of pix+100: first window = {100,101,102,105,106,107,110,111,112}.
- RESET asserted for 1 cycle after pixel 15 of a frame, then a full fresh frame: outputs 0 during reset; exactly 9 correct windows afterwards; no window containing pre-reset data.
- start dropped after pixel 13 (window for 13 already pending), then a new frame: the pending strobe for pixel 13 = {1,2,3,6,7,8,11,12,13} still appears; the next frame yields 9 correct windows.
- Defaults (28x28), random pixels, de duty ~70%: 676 windows, each equal to a reference-model 3x3 extraction; frame_done once.
